// File: rtl/if_id_pkg.sv
// Types and constants shared by the IF/ID boundary: the canonical NOP and the
// layout of one fetched entry.
package if_id_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
        logic            pred_taken;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Small FIFO decoupling instruction fetch from decode. Head is presented from
// state only, so there is no combinational path from any i_* input to the o_* outputs.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int             N     = 32,
    parameter int             DEPTH = 2,
    parameter logic [N-1:0]   NOP   = N'(NOP_INSTR)
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [N-1:0]               i_pc,
    input  logic [N-1:0]               i_instruction,
    input  logic                       i_pred_taken,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [N-1:0]               o_pc,
    output logic [N-1:0]               o_instruction,
    output logic                       o_pred_taken,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0]  pc_mem    [DEPTH];
    logic [N-1:0]  instr_mem [DEPTH];
    logic          pred_mem  [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic          push, pop;

    assign o_ready = (count_reg != CW'(DEPTH));
    assign o_valid = (count_reg != '0);
    assign push    = i_valid && o_ready && !i_flush;
    assign pop     = o_valid && i_ready && !i_flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // DEPTH is a power of two, so pointer increments wrap naturally.
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Payload storage is never reset; entries beyond the count are ignored.
    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= i_pc;
            instr_mem[wr_ptr_reg] <= i_instruction;
            pred_mem[wr_ptr_reg]  <= i_pred_taken;
        end
    end

    assign o_pc          = o_valid ? pc_mem[rd_ptr_reg]    : '0;
    assign o_instruction = o_valid ? instr_mem[rd_ptr_reg] : NOP;
    assign o_pred_taken  = o_valid ? pred_mem[rd_ptr_reg]  : 1'b0;
    assign o_count       = count_reg;

endmodule
